ps2_voice_allocator: RTL and testbench

- Polyphony controller between the PS/2 key-event path and the tone-generator bank.
- Accepts make/break key events, maps scan codes (set 2) to note indices, and assigns each note to one of NUM_VOICES tone-generator voices.
- Frees voices on break; steals the oldest voice when all voices are busy.
- Owns voice assignment exclusively; tone generators only consume voice_active, voice_note and voice_trig.

---
 rtl/ps2_piano_pkg.sv | 53 +++++
 rtl/voice_search.sv | 75 +++++++
 rtl/ps2_voice_allocator.sv | 159 +++++++++++++++
 tb/tb_ps2_voice_allocator.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_piano_pkg.sv
// ps2_piano_pkg
//   Shared definitions for the PS/2 piano voice path: allocator FSM states,
//   set-2 scan codes of the playable keys, and the scan-code to note map.
//   scan_to_note returns {valid, note[3:0]}; valid=0 for any unmapped code.
package ps2_piano_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_SEARCH,
      ST_COMMIT
   } state_t;

   localparam logic [7:0] SC_A = 8'h1C;
   localparam logic [7:0] SC_W = 8'h1D;
   localparam logic [7:0] SC_S = 8'h1B;
   localparam logic [7:0] SC_E = 8'h24;
   localparam logic [7:0] SC_D = 8'h23;
   localparam logic [7:0] SC_F = 8'h2B;
   localparam logic [7:0] SC_T = 8'h2C;
   localparam logic [7:0] SC_G = 8'h34;
   localparam logic [7:0] SC_Y = 8'h35;
   localparam logic [7:0] SC_H = 8'h33;
   localparam logic [7:0] SC_U = 8'h3C;
   localparam logic [7:0] SC_J = 8'h3B;
   localparam logic [7:0] SC_K = 8'h42;

   localparam logic [7:0] BREAK_CODE = 8'hF0;

   function automatic logic [4:0] scan_to_note(input logic [7:0] code);
      logic [4:0] r;
      r = '0;
      case (code)
         SC_A:       r = {1'b1, 4'd0};
         SC_W:       r = {1'b1, 4'd1};
         SC_S:       r = {1'b1, 4'd2};
         SC_E:       r = {1'b1, 4'd3};
         SC_D:       r = {1'b1, 4'd4};
         SC_F:       r = {1'b1, 4'd5};
         SC_T:       r = {1'b1, 4'd6};
         SC_G:       r = {1'b1, 4'd7};
         SC_Y:       r = {1'b1, 4'd8};
         SC_H:       r = {1'b1, 4'd9};
         SC_U:       r = {1'b1, 4'd10};
         SC_J:       r = {1'b1, 4'd11};
         SC_K:       r = {1'b1, 4'd12};
         BREAK_CODE: r = '0;
         default:    r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/voice_search.sv
// voice_search
//   Scans one voice per cycle (index 0..NUM_VOICES-1) while enable is high and
//   keeps the first matching active voice, the first inactive voice and the
//   oldest active voice (highest age, lowest index on ties).
//   Ports: sys_clk/reset, clear (restart scan), enable (advance one voice),
//   voice state inputs (active, notes, ages), target note, last (current
//   index is the final voice), and the registered scan results.
module voice_search
   import ps2_piano_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int NOTE_W     = 4,
   parameter int AGE_W      = 3,
   parameter int IDX_W      = 2
) (
   input  logic                         sys_clk,
   input  logic                         reset,
   input  logic                         clear,
   input  logic                         enable,
   input  logic [NUM_VOICES-1:0]        active,
   input  logic [NUM_VOICES*NOTE_W-1:0] notes,
   input  logic [NUM_VOICES*AGE_W-1:0]  ages,
   input  logic [NOTE_W-1:0]            target,
   output logic                         last,
   output logic                         match_found,
   output logic [IDX_W-1:0]             match_idx,
   output logic                         free_found,
   output logic [IDX_W-1:0]             free_idx,
   output logic [IDX_W-1:0]             oldest_idx
);

   logic [IDX_W-1:0]  idx;
   logic              cur_active;
   logic [NOTE_W-1:0] cur_note;
   logic [AGE_W-1:0]  cur_age;
   logic              oldest_found;
   logic [AGE_W-1:0]  oldest_age;

   always_comb begin
      cur_active = active[idx];
      cur_note   = notes[idx*NOTE_W +: NOTE_W];
      cur_age    = ages[idx*AGE_W +: AGE_W];
      last       = (idx == IDX_W'(NUM_VOICES - 1));
   end

   always_ff @(posedge sys_clk) begin
      if (reset || clear) begin
         idx          <= '0;
         match_found  <= 1'b0;
         match_idx    <= '0;
         free_found   <= 1'b0;
         free_idx     <= '0;
         oldest_found <= 1'b0;
         oldest_idx   <= '0;
         oldest_age   <= '0;
      end else if (enable) begin
         if (cur_active && !match_found && cur_note == target) begin
            match_found <= 1'b1;
            match_idx   <= idx;
         end
         if (!cur_active && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= idx;
         end
         // Strict '>' keeps the lowest index on equal ages.
         if (cur_active && (!oldest_found || cur_age > oldest_age)) begin
            oldest_found <= 1'b1;
            oldest_idx   <= idx;
            oldest_age   <= cur_age;
         end
         idx <= last ? '0 : idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/ps2_voice_allocator.sv
// ps2_voice_allocator
//   Polyphony controller: accepts PS/2 make/break events, maps set-2 scan codes
//   to notes and assigns notes to NUM_VOICES tone-generator voices, stealing
//   the oldest voice when all are busy.
//   Ports: sys_clk, reset (sync, active-high); ev_valid/ev_ready handshake with
//   ev_break/ev_code; voice_active, voice_note (voice i at [i*NOTE_W +: NOTE_W]),
//   voice_trig and steal_pulse (one-cycle registered pulses).
module ps2_voice_allocator
   import ps2_piano_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int NOTE_W     = 4,
   parameter int AGE_W      = 3
) (
   input  logic                         sys_clk,
   input  logic                         reset,
   input  logic                         ev_valid,
   output logic                         ev_ready,
   input  logic                         ev_break,
   input  logic [7:0]                   ev_code,
   output logic [NUM_VOICES-1:0]        voice_active,
   output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
   output logic [NUM_VOICES-1:0]        voice_trig,
   output logic                         steal_pulse
);

   localparam int IDX_W = $clog2(NUM_VOICES);
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);

   state_t state, state_nxt;

   logic [7:0]        code_q;
   logic              brk_q;
   logic [NOTE_W-1:0] note_q;
   logic              lk_valid;
   logic [3:0]        lk_note;

   logic [NUM_VOICES-1:0] active;
   logic [NOTE_W-1:0]     note_r [NUM_VOICES];
   logic [AGE_W-1:0]      age    [NUM_VOICES];
   logic [NUM_VOICES-1:0] trig;
   logic                  steal;

   logic [NUM_VOICES*NOTE_W-1:0] notes_flat;
   logic [NUM_VOICES*AGE_W-1:0]  ages_flat;

   logic             srch_last;
   logic             match_found, free_found;
   logic [IDX_W-1:0] match_idx, free_idx, oldest_idx;

   logic             do_assign, do_release;
   logic [IDX_W-1:0] tgt_idx;

   always_comb begin
      {lk_valid, lk_note} = scan_to_note(code_q);
   end

   always_comb begin
      notes_flat = '0;
      ages_flat  = '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
         notes_flat[i*NOTE_W +: NOTE_W] = note_r[i];
         ages_flat[i*AGE_W +: AGE_W]    = age[i];
      end
   end

   voice_search #(
      .NUM_VOICES (NUM_VOICES),
      .NOTE_W     (NOTE_W),
      .AGE_W      (AGE_W),
      .IDX_W      (IDX_W)
   ) u_search (
      .sys_clk     (sys_clk),
      .reset       (reset),
      .clear       (state == ST_LOOKUP),
      .enable      (state == ST_SEARCH),
      .active      (active),
      .notes       (notes_flat),
      .ages        (ages_flat),
      .target      (note_q),
      .last        (srch_last),
      .match_found (match_found),
      .match_idx   (match_idx),
      .free_found  (free_found),
      .free_idx    (free_idx),
      .oldest_idx  (oldest_idx)
   );

   always_ff @(posedge sys_clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      ev_ready   = 1'b0;
      do_assign  = 1'b0;
      do_release = 1'b0;
      tgt_idx    = free_found ? free_idx : oldest_idx;
      case (state)
         ST_IDLE: begin
            ev_ready = 1'b1;
            if (ev_valid) state_nxt = ST_LOOKUP;
         end
         ST_LOOKUP: state_nxt = lk_valid ? ST_SEARCH : ST_IDLE;
         ST_SEARCH: if (srch_last) state_nxt = ST_COMMIT;
         ST_COMMIT: begin
            state_nxt  = ST_IDLE;
            do_assign  = !brk_q && !match_found;
            do_release = brk_q && match_found;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         code_q <= '0;
         brk_q  <= 1'b0;
         note_q <= '0;
         active <= '0;
         trig   <= '0;
         steal  <= 1'b0;
         for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            note_r[i] <= '0;
            age[i]    <= '0;
         end
      end else begin
         trig  <= '0;
         steal <= do_assign && !free_found;
         if (state == ST_IDLE && ev_valid) begin
            code_q <= ev_code;
            brk_q  <= ev_break;
         end
         if (state == ST_LOOKUP) note_q <= NOTE_W'(lk_note);
         for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (do_assign) begin
               if (IDX_W'(i) == tgt_idx) begin
                  active[i] <= 1'b1;
                  note_r[i] <= note_q;
                  age[i]    <= '0;
                  trig[i]   <= 1'b1;
               end else if (active[i] && age[i] != AGE_MAX) begin
                  age[i] <= age[i] + AGE_W'(1);
               end
            end else if (do_release && IDX_W'(i) == match_idx) begin
               active[i] <= 1'b0;
               age[i]    <= '0;
            end
         end
      end
   end

   assign voice_active = active;
   assign voice_note   = notes_flat;
   assign voice_trig   = trig;
   assign steal_pulse  = steal;

endmodule

// File: tb/tb_ps2_voice_allocator.sv
// tb_ps2_voice_allocator
//   Directed self-checking bench for ps2_voice_allocator with NUM_VOICES=4.
module tb_ps2_voice_allocator;

   logic        sys_clk = 1'b0;
   logic        reset   = 1'b1;
   logic        ev_valid = 1'b0;
   logic        ev_ready;
   logic        ev_break = 1'b0;
   logic [7:0]  ev_code  = '0;
   logic [3:0]  voice_active;
   logic [15:0] voice_note;
   logic [3:0]  voice_trig;
   logic        steal_pulse;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 sys_clk = ~sys_clk;

   ps2_voice_allocator #(
      .NUM_VOICES (4),
      .NOTE_W     (4),
      .AGE_W      (3)
   ) dut (
      .sys_clk      (sys_clk),
      .reset        (reset),
      .ev_valid     (ev_valid),
      .ev_ready     (ev_ready),
      .ev_break     (ev_break),
      .ev_code      (ev_code),
      .voice_active (voice_active),
      .voice_note   (voice_note),
      .voice_trig   (voice_trig),
      .steal_pulse  (steal_pulse)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic edges(input int unsigned k);
      repeat (k) @(posedge sys_clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge sys_clk);
      reset = 1'b1;
      edges(2);
      reset = 1'b0;
   endtask

   // Leaves the caller 1 time unit after the acceptance edge (edge 0).
   task automatic send(input logic brk, input logic [7:0] code);
      int unsigned n;
      n = 0;
      @(negedge sys_clk);
      while (!ev_ready && n < 20) begin
         @(negedge sys_clk);
         n++;
      end
      check("ready_before_send", ev_ready, 1);
      ev_valid = 1'b1;
      ev_break = brk;
      ev_code  = code;
      @(posedge sys_clk);
      #1;
      ev_valid = 1'b0;
   endtask

   task automatic make_settle(input logic [7:0] code);
      send(1'b0, code);
      edges(6);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      edges(3);
      reset = 1'b0;
      check("rst_active", voice_active, 4'b0000);
      check("rst_note", voice_note, 16'h0000);
      check("rst_trig", voice_trig, 4'b0000);
      check("rst_steal", steal_pulse, 0);
      check("rst_ready", ev_ready, 1);

      // Single make: latency and one-cycle trig
      send(1'b0, 8'h1C);
      check("t1_busy", ev_ready, 0);
      edges(5);
      check("t1_early_active", voice_active, 4'b0000);
      check("t1_early_trig", voice_trig, 4'b0000);
      edges(1);
      check("t1_active", voice_active, 4'b0001);
      check("t1_note", voice_note, 16'h0000);
      check("t1_trig", voice_trig, 4'b0001);
      check("t1_ready", ev_ready, 1);
      edges(1);
      check("t1_trig_drop", voice_trig, 4'b0000);

      // Fill all voices, then steal oldest twice
      do_reset();
      make_settle(8'h1C);
      make_settle(8'h1B);
      make_settle(8'h23);
      make_settle(8'h2B);
      check("t2_full_active", voice_active, 4'b1111);
      check("t2_full_note", voice_note, 16'h5420);
      check("t2_full_trig", voice_trig, 4'b1000);
      check("t2_full_steal", steal_pulse, 0);
      make_settle(8'h34);
      check("t2_steal_note", voice_note, 16'h5427);
      check("t2_steal_trig", voice_trig, 4'b0001);
      check("t2_steal_pulse", steal_pulse, 1);
      check("t2_steal_active", voice_active, 4'b1111);
      edges(1);
      check("t2_steal_drop", steal_pulse, 0);
      check("t2_trig_drop", voice_trig, 4'b0000);
      make_settle(8'h35);
      check("t2_steal2_note", voice_note, 16'h5487);
      check("t2_steal2_trig", voice_trig, 4'b0010);
      check("t2_steal2_pulse", steal_pulse, 1);

      // Make then break; break of a silent note
      do_reset();
      make_settle(8'h1B);
      check("t3_make_active", voice_active, 4'b0001);
      send(1'b1, 8'h1B);
      edges(6);
      check("t3_brk_active", voice_active, 4'b0000);
      check("t3_brk_trig", voice_trig, 4'b0000);
      check("t3_brk_note_kept", voice_note, 16'h0002);
      edges(1);
      check("t3_brk_trig_after", voice_trig, 4'b0000);
      send(1'b1, 8'h1C);
      edges(6);
      check("t3_nomatch_active", voice_active, 4'b0000);

      // Duplicate make
      do_reset();
      make_settle(8'h1C);
      make_settle(8'h1C);
      check("t4_dup_active", voice_active, 4'b0001);
      check("t4_dup_trig", voice_trig, 4'b0000);
      check("t4_dup_steal", steal_pulse, 0);

      // Unmapped codes
      send(1'b0, 8'h15);
      check("t5_busy", ev_ready, 0);
      edges(1);
      check("t5_ready_early", ev_ready, 1);
      edges(1);
      check("t5_ready", ev_ready, 1);
      check("t5_active", voice_active, 4'b0001);
      check("t5_note", voice_note, 16'h0000);
      check("t5_trig", voice_trig, 4'b0000);
      send(1'b0, 8'hF0);
      edges(6);
      check("t5_f0_active", voice_active, 4'b0001);
      check("t5_f0_trig", voice_trig, 4'b0000);

      // Reset during SEARCH aborts the event
      make_settle(8'h1B);
      check("t6_pre_active", voice_active, 4'b0011);
      send(1'b0, 8'h23);
      edges(2);
      reset = 1'b1;
      edges(1);
      reset = 1'b0;
      check("t6_rst_active", voice_active, 4'b0000);
      check("t6_rst_note", voice_note, 16'h0000);
      check("t6_rst_trig", voice_trig, 4'b0000);
      check("t6_rst_ready", ev_ready, 1);
      edges(8);
      check("t6_after_active", voice_active, 4'b0000);
      check("t6_after_trig", voice_trig, 4'b0000);
      check("t6_after_steal", steal_pulse, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
